// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer: FSM state encoding,
// instruction opcodes, ALU function codes and bus source selects.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    // Opcodes carried in IR[31:27]
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU function selects; OR doubles as the idle value outside T4
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_IDLE = ALU_OR;

    // Bus source selects; codes 0_rrrr address general-purpose registers
    localparam logic [4:0] BUS_NONE = 5'b00000;
    localparam logic [4:0] BUS_Z_LO = 5'b10011;
    localparam logic [4:0] BUS_PC   = 5'b10100;
    localparam logic [4:0] BUS_MDR  = 5'b10101;

    // Bus select for general-purpose register r
    function automatic logic [4:0] gpSource(input logic [3:0] reg_idx);
        return {1'b0, reg_idx};
    endfunction

endpackage

// File: rtl/op_decoder.sv
// Opcode classifier and ALU function map for the control sequencer.
// Purely combinational; exactly one of alu_class/is_nop/is_halt/is_illegal
// is high for any opcode.
module op_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output logic       alu_class,
    output logic       is_nop,
    output logic       is_halt,
    output logic       is_illegal,
    output logic [3:0] alu_op
);

    // Classify the opcode and pick the ALU function for ALU-class instructions
    always_comb begin
        alu_class  = 1'b0;
        is_nop     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        alu_op     = ALU_IDLE;
        case (opcode)
            OP_ADD: begin
                alu_class = 1'b1;
                alu_op    = ALU_ADD;
            end
            OP_OR: begin
                alu_class = 1'b1;
                alu_op    = ALU_OR;
            end
            OP_AND: begin
                alu_class = 1'b1;
                alu_op    = ALU_AND;
            end
            OP_SUB: begin
                alu_class = 1'b1;
                alu_op    = ALU_SUB;
            end
            OP_NOP:  is_nop     = 1'b1;
            OP_HALT: is_halt    = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute control sequencer. A Moore FSM walks IDLE -> T0..T5 for
// register-to-register ALU instructions, branching in T3 on the opcode class.
// Outputs are decoded from the state register and IR; only the T1 PC/MDR
// loads follow mem_ready so the PC advances once per fetch.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] IR,
    output logic [4:0]  BusDataSelect,
    output logic [3:0]  GP_addr,
    output logic        e_PC,
    output logic        e_IR,
    output logic        e_Y,
    output logic        e_Z,
    output logic        e_MAR,
    output logic        e_MDR,
    output logic        e_GP,
    output logic        e_HI,
    output logic        e_LO,
    output logic        incPC,
    output logic        MDR_read,
    output logic [3:0]  ALU_op,
    output logic        halted,
    output logic        illegal
);

    state_t     r_state;
    state_t     w_nextState;
    logic       r_startOk;

    logic [4:0] w_opcode;
    logic [3:0] w_ra;
    logic [3:0] w_rb;
    logic [3:0] w_rc;
    logic       w_unusedIrBits;

    logic       w_aluClass;
    logic       w_isNop;
    logic       w_isHalt;
    logic       w_isIllegal;
    logic [3:0] w_aluOp;

    assign w_opcode       = IR[31:27];
    assign w_ra           = IR[26:23];
    assign w_rb           = IR[22:19];
    assign w_rc           = IR[18:15];
    assign w_unusedIrBits = ^IR[14:0];

    assign e_HI = 1'b0;
    assign e_LO = 1'b0;

    op_decoder u_opDecoder (
        .opcode     (w_opcode),
        .alu_class  (w_aluClass),
        .is_nop     (w_isNop),
        .is_halt    (w_isHalt),
        .is_illegal (w_isIllegal),
        .alu_op     (w_aluOp)
    );

    // Hold off the first fetch for one edge after reset release
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_startOk <= 1'b0;
        end else begin
            r_startOk <= 1'b1;
        end
    end

    // State register; clear forces IDLE from any state, HALT included
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and control-word decode from the current state and IR
    always_comb begin
        w_nextState   = r_state;
        BusDataSelect = BUS_NONE;
        GP_addr       = 4'b0000;
        e_PC          = 1'b0;
        e_IR          = 1'b0;
        e_Y           = 1'b0;
        e_Z           = 1'b0;
        e_MAR         = 1'b0;
        e_MDR         = 1'b0;
        e_GP          = 1'b0;
        incPC         = 1'b0;
        MDR_read      = 1'b0;
        ALU_op        = ALU_IDLE;
        halted        = 1'b0;
        illegal       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run && r_startOk) begin
                    w_nextState = ST_T0;
                end
            end
            ST_T0: begin
                BusDataSelect = BUS_PC;
                e_MAR         = 1'b1;
                incPC         = 1'b1;
                e_Z           = 1'b1;
                w_nextState   = ST_T1;
            end
            ST_T1: begin
                BusDataSelect = BUS_Z_LO;
                MDR_read      = 1'b1;
                e_PC          = mem_ready;
                e_MDR         = mem_ready;
                w_nextState   = mem_ready ? ST_T2 : ST_T1;
            end
            ST_T2: begin
                BusDataSelect = BUS_MDR;
                e_IR          = 1'b1;
                w_nextState   = ST_T3;
            end
            ST_T3: begin
                if (w_aluClass) begin
                    BusDataSelect = gpSource(w_rb);
                    e_Y           = 1'b1;
                    w_nextState   = ST_T4;
                end else if (w_isHalt) begin
                    w_nextState = ST_HALT;
                end else if (w_isIllegal) begin
                    illegal     = 1'b1;
                    w_nextState = ST_IDLE;
                end else begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_T4: begin
                BusDataSelect = gpSource(w_rc);
                ALU_op        = w_aluOp;
                e_Z           = 1'b1;
                w_nextState   = ST_T5;
            end
            ST_T5: begin
                BusDataSelect = BUS_Z_LO;
                GP_addr       = w_ra;
                e_GP          = 1'b1;
                w_nextState   = ST_IDLE;
            end
            ST_HALT: begin
                halted      = 1'b1;
                w_nextState = ST_HALT;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a table of per-cycle vectors
// plus hand-written sequences for HALT and asynchronous clear.
module tb_control_sequencer;

    typedef struct packed {
        logic [4:0] bds;
        logic [3:0] gpAddr;
        logic       ePC;
        logic       eIR;
        logic       eY;
        logic       eZ;
        logic       eMAR;
        logic       eMDR;
        logic       eGP;
        logic       eHI;
        logic       eLO;
        logic       incPC;
        logic       mdrRead;
        logic [3:0] aluOp;
        logic       halted;
        logic       illegal;
    } outs_t;

    typedef struct {
        string       name;
        logic        run;
        logic        memReady;
        logic [31:0] ir;
        outs_t       exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        clear;
    logic        run;
    logic        mem_ready;
    logic [31:0] IR;
    logic [4:0]  BusDataSelect;
    logic [3:0]  GP_addr;
    logic        e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, e_GP, e_HI, e_LO;
    logic        incPC;
    logic        MDR_read;
    logic [3:0]  ALU_op;
    logic        halted;
    logic        illegal;

    outs_t       actual;
    outs_t       expQ[$];
    string       nameQ[$];
    vec_t        vecs[$];
    int          checks   = 0;
    int          failures = 0;

    control_sequencer dut (
        .clock         (clock),
        .clear         (clear),
        .run           (run),
        .mem_ready     (mem_ready),
        .IR            (IR),
        .BusDataSelect (BusDataSelect),
        .GP_addr       (GP_addr),
        .e_PC          (e_PC),
        .e_IR          (e_IR),
        .e_Y           (e_Y),
        .e_Z           (e_Z),
        .e_MAR         (e_MAR),
        .e_MDR         (e_MDR),
        .e_GP          (e_GP),
        .e_HI          (e_HI),
        .e_LO          (e_LO),
        .incPC         (incPC),
        .MDR_read      (MDR_read),
        .ALU_op        (ALU_op),
        .halted        (halted),
        .illegal       (illegal)
    );

    assign actual = {BusDataSelect, GP_addr, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR,
                     e_GP, e_HI, e_LO, incPC, MDR_read, ALU_op, halted, illegal};

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clock = ~clock;

    function automatic outs_t expIdle();
        outs_t e;
        e       = '0;
        e.aluOp = 4'b0001;
        return e;
    endfunction

    function automatic outs_t expT0();
        outs_t e;
        e       = expIdle();
        e.bds   = 5'b10100;
        e.eMAR  = 1'b1;
        e.incPC = 1'b1;
        e.eZ    = 1'b1;
        return e;
    endfunction

    function automatic outs_t expT1(input logic m);
        outs_t e;
        e         = expIdle();
        e.bds     = 5'b10011;
        e.mdrRead = 1'b1;
        e.ePC     = m;
        e.eMDR    = m;
        return e;
    endfunction

    function automatic outs_t expT2();
        outs_t e;
        e     = expIdle();
        e.bds = 5'b10101;
        e.eIR = 1'b1;
        return e;
    endfunction

    function automatic outs_t expT3(input logic [3:0] rb);
        outs_t e;
        e     = expIdle();
        e.bds = {1'b0, rb};
        e.eY  = 1'b1;
        return e;
    endfunction

    function automatic outs_t expT4(input logic [3:0] rc, input logic [3:0] op);
        outs_t e;
        e       = expIdle();
        e.bds   = {1'b0, rc};
        e.aluOp = op;
        e.eZ    = 1'b1;
        return e;
    endfunction

    function automatic outs_t expT5(input logic [3:0] ra);
        outs_t e;
        e        = expIdle();
        e.bds    = 5'b10011;
        e.gpAddr = ra;
        e.eGP    = 1'b1;
        return e;
    endfunction

    function automatic outs_t expHalt();
        outs_t e;
        e        = expIdle();
        e.halted = 1'b1;
        return e;
    endfunction

    function automatic outs_t expIllegal();
        outs_t e;
        e         = expIdle();
        e.illegal = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] mkIr(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'h0000};
    endfunction

    task automatic addVec(input string n, input logic r, input logic m,
                          input logic [31:0] ir, input outs_t e);
        vec_t v;
        v.name     = n;
        v.run      = r;
        v.memReady = m;
        v.ir       = ir;
        v.exp      = e;
        vecs.push_back(v);
    endtask

    // Pop the oldest expectation and compare it with the DUT outputs now
    task automatic checkOutput();
        outs_t e;
        string n;
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checks++;
        if (actual !== e) begin
            failures++;
            $display("[TB] FAIL %s: got %07h expected %07h (t=%0t)", n, actual, e, $time);
        end
    endtask

    // Check the outputs right now without waiting for a clock edge
    task automatic checkNow(input string n, input outs_t e);
        expQ.push_back(e);
        nameQ.push_back(n);
        checkOutput();
    endtask

    // Drive one cycle of inputs after the falling edge, queue the expectation, compare
    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        run       = v.run;
        mem_ready = v.memReady;
        IR        = v.ir;
        expQ.push_back(v.exp);
        nameQ.push_back(v.name);
        #1;
        checkOutput();
    endtask

    task automatic stepCheck(input string n, input logic r, input logic m,
                             input logic [31:0] ir, input outs_t e);
        vec_t v;
        v.name     = n;
        v.run      = r;
        v.memReady = m;
        v.ir       = ir;
        v.exp      = e;
        applyStimulus(v);
    endtask

    initial begin
        logic [31:0] irOr;
        logic [31:0] irAdd;
        logic [31:0] irSub;
        logic [31:0] irAnd;
        logic [31:0] irBad;
        logic [31:0] irNop;
        logic [31:0] irHalt;
        logic [31:0] irAbort;

        irOr    = 32'h2A2C8000;
        irAdd   = mkIr(5'b00011, 4'd1, 4'd2, 4'd3);
        irSub   = mkIr(5'b00100, 4'd6, 4'd10, 4'd11);
        irAnd   = mkIr(5'b00110, 4'd0, 4'd15, 4'd7);
        irBad   = mkIr(5'b11111, 4'd5, 4'd5, 4'd5);
        irNop   = mkIr(5'b11010, 4'd2, 4'd3, 4'd4);
        irHalt  = mkIr(5'b11011, 4'd0, 4'd0, 4'd0);
        irAbort = mkIr(5'b00100, 4'd7, 4'd8, 4'd9);

        // OR r4 <- r5 | r9, zero wait; also shows the first T0 two edges after release
        addVec("or_idle",   1, 1, irOr, expIdle());
        addVec("or_t0",     1, 1, irOr, expT0());
        addVec("or_t1",     1, 1, irOr, expT1(1'b1));
        addVec("or_t2",     1, 1, irOr, expT2());
        addVec("or_t3",     1, 1, irOr, expT3(4'b0101));
        addVec("or_t4",     1, 1, irOr, expT4(4'b1001, 4'b0001));
        addVec("or_t5",     1, 1, irOr, expT5(4'b0100));
        addVec("or_idle2",  1, 1, irOr, expIdle());
        // ADD with three memory wait cycles in T1
        addVec("add_t0",    1, 1, irAdd, expT0());
        addVec("add_t1w0",  1, 0, irAdd, expT1(1'b0));
        addVec("add_t1w1",  1, 0, irAdd, expT1(1'b0));
        addVec("add_t1w2",  1, 0, irAdd, expT1(1'b0));
        addVec("add_t1rdy", 1, 1, irAdd, expT1(1'b1));
        addVec("add_t2",    1, 1, irAdd, expT2());
        addVec("add_t3",    1, 1, irAdd, expT3(4'd2));
        addVec("add_t4",    1, 1, irAdd, expT4(4'd3, 4'b0000));
        addVec("add_t5",    1, 1, irAdd, expT5(4'd1));
        addVec("add_idle",  1, 1, irAdd, expIdle());
        // SUB with run dropped in T2: completes, then parks in IDLE
        addVec("sub_t0",    1, 1, irSub, expT0());
        addVec("sub_t1",    1, 1, irSub, expT1(1'b1));
        addVec("sub_t2",    0, 1, irSub, expT2());
        addVec("sub_t3",    0, 1, irSub, expT3(4'd10));
        addVec("sub_t4",    0, 1, irSub, expT4(4'd11, 4'b0011));
        addVec("sub_t5",    0, 1, irSub, expT5(4'd6));
        addVec("sub_park0", 0, 1, irSub, expIdle());
        addVec("sub_park1", 0, 1, irSub, expIdle());
        addVec("sub_park2", 0, 1, irSub, expIdle());
        // Undefined opcode: one-cycle illegal pulse in T3, back to IDLE
        addVec("bad_idle",  1, 1, irBad, expIdle());
        addVec("bad_t0",    1, 1, irBad, expT0());
        addVec("bad_t1",    1, 1, irBad, expT1(1'b1));
        addVec("bad_t2",    1, 1, irBad, expT2());
        addVec("bad_t3",    1, 1, irBad, expIllegal());
        addVec("bad_after", 0, 1, irBad, expIdle());
        // NOP: no enables in T3, back to IDLE
        addVec("nop_idle",  1, 1, irNop, expIdle());
        addVec("nop_t0",    1, 1, irNop, expT0());
        addVec("nop_t1",    1, 1, irNop, expT1(1'b1));
        addVec("nop_t2",    1, 1, irNop, expT2());
        addVec("nop_t3",    1, 1, irNop, expIdle());
        addVec("nop_after", 0, 1, irNop, expIdle());
        // AND into r0 still asserts e_GP
        addVec("and_idle",  1, 1, irAnd, expIdle());
        addVec("and_t0",    1, 1, irAnd, expT0());
        addVec("and_t1",    1, 1, irAnd, expT1(1'b1));
        addVec("and_t2",    1, 1, irAnd, expT2());
        addVec("and_t3",    1, 1, irAnd, expT3(4'd15));
        addVec("and_t4",    1, 1, irAnd, expT4(4'd7, 4'b0010));
        addVec("and_t5",    1, 1, irAnd, expT5(4'd0));
        addVec("and_after", 0, 1, irAnd, expIdle());

        clear     = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b0;
        IR        = 32'h0;
        #2;
        checkNow("reset_idle", expIdle());
        run       = 1'b1;
        mem_ready = 1'b1;
        IR        = irOr;
        repeat (2) @(posedge clock);
        #1;
        checkNow("reset_hold", expIdle());

        @(negedge clock);
        clear = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // HALT: sticky regardless of run, left only through clear
        stepCheck("halt_idle", 1, 1, irHalt, expIdle());
        stepCheck("halt_t0",   1, 1, irHalt, expT0());
        stepCheck("halt_t1",   1, 1, irHalt, expT1(1'b1));
        stepCheck("halt_t2",   1, 1, irHalt, expT2());
        stepCheck("halt_t3",   1, 1, irHalt, expIdle());
        for (int i = 0; i < 4; i++) begin
            stepCheck("halt_hold", logic'(i % 2), 1, irHalt, expHalt());
        end
        @(negedge clock);
        #1;
        clear = 1'b0;
        #1;
        checkNow("halt_clear", expIdle());
        @(negedge clock);
        clear = 1'b1;

        // Clear asserted in the middle of T4 aborts without an e_GP
        stepCheck("abort_idle", 1, 1, irAbort, expIdle());
        stepCheck("abort_t0",   1, 1, irAbort, expT0());
        stepCheck("abort_t1",   1, 1, irAbort, expT1(1'b1));
        stepCheck("abort_t2",   1, 1, irAbort, expT2());
        stepCheck("abort_t3",   1, 1, irAbort, expT3(4'd8));
        stepCheck("abort_t4",   1, 1, irAbort, expT4(4'd9, 4'b0011));
        #1;
        clear = 1'b0;
        #1;
        checkNow("abort_async", expIdle());
        stepCheck("abort_held0", 1, 1, irAbort, expIdle());
        stepCheck("abort_held1", 1, 1, irAbort, expIdle());
        @(negedge clock);
        clear = 1'b1;
        stepCheck("restart_idle", 1, 1, irAbort, expIdle());
        stepCheck("restart_t0",   1, 1, irAbort, expT0());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
